// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: state encodings and default width.
package serial_adder_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle for the serial adder: operands and start in, status and result out.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (output start, A, B, Cin, input busy, done, S, Cout);
    modport slave  (input start, A, B, Cin, output busy, done, S, Cout);
endinterface

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR.
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    logic w_hs1_s;
    logic w_hs1_c;
    logic w_hs2_c;

    assign w_hs1_s = i_a ^ i_b;
    assign w_hs1_c = i_a & i_b;
    assign o_s     = w_hs1_s ^ i_cin;
    assign w_hs2_c = w_hs1_s & i_cin;
    assign o_cout  = w_hs1_c | w_hs2_c;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequencer that runs one full-adder cell LSB-first over WIDTH bits with a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    // Holds only the WIDTH-1 bits already produced; the final bit goes straight into S.
    logic [WIDTH-2:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_S;
    logic             r_Cout;
    logic             r_busy;
    logic             r_done;

    logic             w_s_bit;
    logic             w_c_bit;
    logic [WIDTH-1:0] w_sum_next;

    fa_cell u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_s    (w_s_bit),
        .o_cout (w_c_bit)
    );

    assign w_sum_next = {w_s_bit, r_sum_sh};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_S      <= '0;
            r_Cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sh  <= bus.A;
                        r_b_sh  <= bus.B;
                        r_carry <= bus.Cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_carry  <= w_c_bit;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_next[WIDTH-1:1];
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_S     <= w_sum_next;
                        r_Cout  <= w_c_bit;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.S    = r_S;
    assign bus.Cout = r_Cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 with hand-computed sums.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; inputs are scrambled during RUN to show they are not re-sampled.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic ec,
                          input logic [W-1:0] ps, input logic pc, input string tag);
        bus.A = a; bus.B = b; bus.Cin = cin; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.A = ~a; bus.B = ~b; bus.Cin = ~cin;
        for (int i = 0; i < W; i++) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
            chk({tag, "_Shold"}, 32'(bus.S), 32'(ps));
            chk({tag, "_Chold"}, 32'(bus.Cout), 32'(pc));
            tick();
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_idlebusy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_S"}, 32'(bus.S), 32'(es));
        chk({tag, "_Cout"}, 32'(bus.Cout), 32'(ec));
        tick();
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_Cout", 32'(bus.Cout), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0, "t1");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, "t2");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, "t3");
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, "t3z");

        // start pulse during RUN is ignored
        bus.A = 8'h12; bus.B = 8'h34; bus.Cin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.A = 8'hAA; bus.B = 8'h77; bus.Cin = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < W - 2; i++) begin
            chk("t4_busy", 32'(bus.busy), 32'd1);
            chk("t4_nodone", 32'(bus.done), 32'd0);
            tick();
        end
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_S", 32'(bus.S), 32'h46);
        chk("t4_Cout", 32'(bus.Cout), 32'd0);
        tick();
        chk("t4_single", 32'(bus.done), 32'd0);
        chk("t4_idle", 32'(bus.busy), 32'd0);

        // back-to-back with start held high
        bus.A = 8'h80; bus.B = 8'h80; bus.Cin = 1'b0; bus.start = 1'b1;
        tick();
        for (int i = 0; i < W; i++) begin
            chk("t5a_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        chk("t5a_done", 32'(bus.done), 32'd1);
        chk("t5a_S", 32'(bus.S), 32'h00);
        chk("t5a_Cout", 32'(bus.Cout), 32'd1);
        bus.A = 8'h01; bus.B = 8'h02;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk("t5b_busy", 32'(bus.busy), 32'd1);
            chk("t5b_nodone", 32'(bus.done), 32'd0);
            tick();
        end
        chk("t5b_done", 32'(bus.done), 32'd1);
        chk("t5b_S", 32'(bus.S), 32'h03);
        chk("t5b_Cout", 32'(bus.Cout), 32'd0);
        tick();
        chk("t5b_pulse", 32'(bus.done), 32'd0);

        // reset in the 4th RUN cycle
        bus.A = 8'h55; bus.B = 8'h55; bus.Cin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        chk("t6_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_done", 32'(bus.done), 32'd0);
        chk("t6_S", 32'(bus.S), 32'd0);
        chk("t6_Cout", 32'(bus.Cout), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            chk("t6_nodone", 32'(bus.done), 32'd0);
            chk("t6_nobusy", 32'(bus.busy), 32'd0);
        end
        run_op(8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 8'h00, 1'b0, "t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. It time-multiplexes one 1-bit full-adder cell across two WIDTH-bit operands, LSB first, one bit per clock.
- It provides a start/busy/done handshake, holds the carry between bits in a register, and registers the final sum and carry-out.
- Sits in the lab arithmetic datapath as the sequencer that turns the single-bit adder into a multi-bit adder.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request to begin an addition; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse; S and Cout are valid from this cycle onward.
- S  output  WIDTH  registered sum of the last completed operation.
- Cout  output  1  registered carry-out of the last completed operation.

Behaviour:
- Reset (rst_n=0 at a rising edge), including mid-operation:
  - state goes to IDLE; busy=0, done=0, S=0, Cout=0.
  - shift registers, carry register and bit counter are cleared.
  - an in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge E0: load A->a_sh, B->b_sh, Cin->carry; clear cnt; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Each edge: the cell computes s_bit/c_bit from a_sh[0], b_sh[0] and carry.
  - carry <= c_bit; a_sh and b_sh shift right by 1; s_bit shifts into the MSB of sum_sh; cnt increments.
  - When cnt==WIDTH-1 at an edge (edge E0+WIDTH): S <= {s_bit, sum_sh[WIDTH-1:1]}, Cout <= c_bit, go to DONE.
  - start is ignored in RUN; A, B and Cin may change freely without effect.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge: start=1 is accepted as in IDLE (back-to-back operation, go to RUN); otherwise go to IDLE.
- Latency:
  - start accepted at edge E0; done high in the cycle after edge E0+WIDTH.
  - Throughput is one operation per WIDTH+1 cycles.
- S and Cout hold their value until the next completion; they do not change during RUN.
- Arithmetic: {Cout,S} = A + B + Cin exactly, modulo 2^(WIDTH+1).
- Bit counter width: $clog2(WIDTH); counter wrap is never reached because of the RUN exit condition.
- No combinational path from inputs to outputs.

Decomposition:
- Shared header/package:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default WIDTH constant.
- Sub-module fa_cell: combinational 1-bit full adder (S, Cout, A, B, Cin), built from two half adders plus an OR.
  - Instantiated once; the controller owns all registers.

Test Plan:
- WIDTH=8, reset, then A=0x0F, B=0x01, Cin=0, start pulse -> busy high for 8 cycles; done pulses 9 cycles after the start edge; S=0x10, Cout=0.
- A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1 (full carry ripple across all bits).
- A=0xFF, B=0xFF, Cin=1 -> S=0xFF, Cout=1. Then A=0x00, B=0x00, Cin=0 -> S=0x00, Cout=0.
- Start A=0x12, B=0x34; during RUN, pulse start with A=0xAA and change B -> ignored; single done with S=0x46, Cout=0.
- Hold start=1 continuously with A=0x80, B=0x80, then A=0x01, B=0x02 presented in the DONE cycle:
  - first done gives S=0x00, Cout=1;
  - second operation starts immediately (no IDLE cycle) and gives S=0x03, Cout=0.
- Start A=0x55, B=0x55; assert rst_n=0 on the 4th RUN cycle -> next cycle busy=0, done=0, S=0, Cout=0, state IDLE; no done pulse follows.
